// File: rtl/apb3_timer_irq.sv
// rtl/apb3_timer_irq.sv - APB3 prescaled down-counter timer with level interrupt
module apb3_timer_irq #(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int PRE_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERROR,
    output logic                  irq
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRE    = 3'd4;

    logic                 r_enable;
    logic                 r_auto_reload;
    logic                 r_irq_en;
    logic                 r_pending;
    logic [CNT_WIDTH-1:0] r_load;
    logic [CNT_WIDTH-1:0] r_count;
    logic [PRE_WIDTH-1:0] r_prescale;
    logic [PRE_WIDTH-1:0] r_pre_cnt;

    logic [2:0]  w_offset;
    logic        w_mapped;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_status;
    logic        w_wr_pre;
    logic        w_start;
    logic        w_tick;
    logic        w_expire;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_offset    = PADDR[4:2];
    assign w_mapped    = (w_offset <= OFF_PRE);
    assign w_wr        = PSEL & PENABLE & PWRITE;
    assign w_wr_ctrl   = w_wr & (w_offset == OFF_CTRL);
    assign w_wr_load   = w_wr & (w_offset == OFF_LOAD);
    assign w_wr_status = w_wr & (w_offset == OFF_STATUS);
    assign w_wr_pre    = w_wr & (w_offset == OFF_PRE);

    // Only a 0->1 enable transition restarts; rewriting enable=1 leaves the count alone.
    assign w_start  = w_wr_ctrl & PWDATA[0] & ~r_enable;
    assign w_tick   = r_enable & (r_pre_cnt == r_prescale);
    assign w_expire = w_tick & (r_count == '0);

    assign w_unused = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0], PWDATA};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_enable      <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_pending     <= 1'b0;
            r_load        <= '0;
            r_count       <= '0;
            r_prescale    <= '0;
            r_pre_cnt     <= '0;
        end else begin
            if (w_start) begin
                r_pre_cnt <= '0;
            end else if (r_enable) begin
                r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            end

            // Reload uses the pre-edge LOAD, so a same-cycle LOAD write applies next time.
            if (w_start) begin
                r_count <= r_load;
            end else if (w_tick) begin
                if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end else if (r_auto_reload) begin
                    r_count <= r_load;
                end
            end

            if (w_expire && !r_auto_reload) begin
                r_enable <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_enable      <= PWDATA[0];
                r_auto_reload <= PWDATA[1];
                r_irq_en      <= PWDATA[2];
            end

            if (w_wr_load) begin
                r_load <= PWDATA[CNT_WIDTH-1:0];
            end
            if (w_wr_pre) begin
                r_prescale <= PWDATA[PRE_WIDTH-1:0];
            end

            // Hardware set beats a same-cycle W1C so no expiry is ever lost.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (w_wr_status && PWDATA[0]) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_offset)
            OFF_CTRL:   w_rdata = {29'd0, r_irq_en, r_auto_reload, r_enable};
            OFF_LOAD:   w_rdata = 32'(r_load);
            OFF_COUNT:  w_rdata = 32'(r_count);
            OFF_STATUS: w_rdata = {31'd0, r_pending};
            OFF_PRE:    w_rdata = 32'(r_prescale);
            default:    w_rdata = '0;
        endcase
    end

    assign PRDATA    = PSEL ? w_rdata : 32'd0;
    assign PREADY    = 1'b1;
    assign PSLVERROR = PSEL & PENABLE & ~w_mapped;
    assign irq       = r_pending & r_irq_en;

endmodule
